layer_4_maxpool: RTL and testbench

LAYER_4_MAXPOOL -- requirements
Module: layer_4_maxpool

---
 rtl/layer_4_maxpool.sv | 113 +++++++++++
 tb/tb_layer_4_maxpool.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_4_maxpool.sv
// rtl/layer_4_maxpool.sv - 2x2/stride-2 FP32 max-pool over a raster-order feature map.
// Optional frame_done output enabled by defining LAYER_4_MAXPOOL_FRAME_DONE_EN.
module layer_4_maxpool #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int CW       = $clog2(IMG_SIZE);
    localparam int LBW      = CW - 1;
    localparam int LB_DEPTH = IMG_SIZE / 2;
    localparam int MSB      = DATA_WIDTH - 1;

    // Sign-magnitude total order; +0 ranks above -0, NaN/Inf are just bit patterns.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (a[MSB] != b[MSB]) return !a[MSB];
        if (!a[MSB])          return a[MSB-1:0] > b[MSB-1:0];
        return a[MSB-1:0] < b[MSB-1:0];
    endfunction

    // The earlier operand survives a tie.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] early,
                                                     input logic [DATA_WIDTH-1:0] late);
        return fp_gt(late, early) ? late : early;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] linebuf_q [0:LB_DEPTH-1];

    logic                  col_last, row_last, lb_we;
    logic [LBW-1:0]        lb_idx;
    logic [DATA_WIDTH-1:0] pair_max, win_max;

    assign col_last = (col_q == CW'(IMG_SIZE - 1));
    assign row_last = (row_q == CW'(IMG_SIZE - 1));
    assign lb_idx   = col_q[CW-1:1];
    assign pair_max = fp_max(pair_q, data_in);
    assign win_max  = fp_max(linebuf_q[lb_idx], pair_max);
    assign lb_we    = valid_in && col_q[0] && !row_q[0];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        if (valid_in) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            if (!col_q[0]) begin
                pair_d = data_in;
            end else if (row_q[0]) begin
                data_out_d   = win_max;
                valid_out_d  = 1'b1;
                frame_done_d = row_last && col_last;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Entries are always rewritten on an even row before being read, so no reset.
    always_ff @(posedge Clk) begin
        if (Rst && lb_we) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
    assign frame_done = frame_done_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_layer_4_maxpool.sv
// tb/tb_layer_4_maxpool.sv - directed and model-checked bench for layer_4_maxpool.
module tb_layer_4_maxpool;

    localparam int BIG  = 104;
    localparam int FOUT = (BIG / 2) * (BIG / 2);

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] d4_in, d4_out, d104_in, d104_out;
    logic        v4_in, v4_out, v104_in, v104_out;
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
    logic        fd4, fd104;
`endif

    always #5 Clk = ~Clk;

    layer_4_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .data_in(d4_in), .valid_in(v4_in),
        .data_out(d4_out), .valid_out(v4_out)
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
        , .frame_done(fd4)
`endif
    );

    layer_4_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(BIG)) dut104 (
        .Clk(Clk), .Rst(Rst), .data_in(d104_in), .valid_in(v104_in),
        .data_out(d104_out), .valid_out(v104_out)
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
        , .frame_done(fd104)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Order-preserving integer key: larger key means larger float in the total order.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h3F80_0000;
            default: return $urandom();
        endcase
    endfunction

    logic [31:0] fr4 [16];
    logic [31:0] ex4 [4];

    task automatic run4(input string tag, input int maxgap);
        int k;
        int g;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            d4_in = fr4[i];
            v4_in = 1'b1;
            step();
            v4_in = 1'b0;
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                chk({tag, " valid"}, 32'(v4_out), 32'd1);
                chk({tag, " data"}, d4_out, ex4[k]);
                k++;
            end else begin
                chk({tag, " idle"}, 32'(v4_out), 32'd0);
            end
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
            chk({tag, " frame_done"}, 32'(fd4), 32'(i == 15));
`endif
            g = $urandom_range(0, maxgap);
            for (int j = 0; j < g; j++) begin
                step();
                chk({tag, " gap valid"}, 32'(v4_out), 32'd0);
                if (k > 0) chk({tag, " gap hold"}, d4_out, ex4[k-1]);
            end
        end
    endtask

    logic [31:0] img [BIG][BIG];
    logic [31:0] expq [$];
    int r104 = 0;
    int c104 = 0;
    int n_out = 0;

    task automatic px104(input logic [31:0] d, input int maxgap);
        int g;
        img[r104][c104] = d;
        if ((r104 % 2 == 1) && (c104 % 2 == 1))
            expq.push_back(mx(mx(img[r104-1][c104-1], img[r104-1][c104]),
                              mx(img[r104][c104-1], d)));
        d104_in = d;
        v104_in = 1'b1;
        step();
        v104_in = 1'b0;
        c104++;
        if (c104 == BIG) begin
            c104 = 0;
            r104 = (r104 + 1) % BIG;
        end
        g = $urandom_range(0, maxgap);
        for (int j = 0; j < g; j++) step();
    endtask

    always @(negedge Clk) begin
        if (Rst === 1'b1) begin
            if (v104_out) begin
                n_out++;
                if (expq.size() == 0) chk("out104 unexpected", 32'(v104_out), 32'd0);
                else                  chk("out104 data", d104_out, expq.pop_front());
            end
`ifdef LAYER_4_MAXPOOL_FRAME_DONE_EN
            if (v104_out || fd104)
                chk("out104 frame_done", 32'(fd104), 32'(v104_out && (n_out % FOUT == 0)));
`endif
        end
    end

    initial begin
        Rst     = 1'b0;
        v4_in   = 1'b0;
        v104_in = 1'b0;
        d4_in   = '0;
        d104_in = '0;
        repeat (3) step();
        chk("reset d4_out", d4_out, 32'h0);
        chk("reset v4_out", 32'(v4_out), 32'd0);
        chk("reset d104_out", d104_out, 32'h0);
        chk("reset v104_out", 32'(v104_out), 32'd0);
        Rst = 1'b1;

        fr4 = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
        ex4 = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
        run4("ramp", 0);

        fr4 = '{default: 32'h0};
        fr4[0]  = 32'hBF80_0000; fr4[1]  = 32'hC000_0000;
        fr4[4]  = 32'hBF00_0000; fr4[5]  = 32'hC040_0000;
        fr4[8]  = 32'hC180_0000; fr4[9]  = 32'h3F80_0000;
        fr4[12] = 32'h7F80_0000; fr4[13] = 32'hFF80_0000;
        fr4[10] = 32'hC000_0000; fr4[11] = 32'h8000_0000;
        fr4[14] = 32'hBF80_0000; fr4[15] = 32'hC040_0000;
        ex4 = '{32'hBF00_0000, 32'h0000_0000, 32'h7F80_0000, 32'h8000_0000};
        run4("neg", 2);

        fr4 = '{default: 32'h0};
        fr4[1] = 32'h8000_0000; fr4[4] = 32'h8000_0000; fr4[5] = 32'h8000_0000;
        fr4[2] = 32'h8000_0000; fr4[3] = 32'h8000_0000;
        fr4[6] = 32'h8000_0000; fr4[7] = 32'h8000_0000;
        ex4 = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        run4("zero_a", 1);

        fr4 = '{default: 32'h8000_0000};
        fr4[1] = 32'h0000_0000;
        ex4 = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        run4("zero_b", 0);

        for (int i = 0; i < BIG * BIG; i++) px104(rnd(), 5);
        repeat (3) step();
        chk("gapped frame count", n_out, FOUT);

        for (int i = 0; i < 57; i++) px104(rnd(), 0);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d104_in = $urandom();
            v104_in = 1'b1;
            d4_in   = $urandom();
            v4_in   = 1'b1;
            step();
            chk("in reset v104_out", 32'(v104_out), 32'd0);
            chk("in reset v4_out", 32'(v4_out), 32'd0);
        end
        v104_in = 1'b0;
        v4_in   = 1'b0;
        chk("after reset d104_out", d104_out, 32'h0);
        chk("partial frame pending", expq.size(), 32'd0);
        chk("partial frame count", n_out, FOUT);
        expq.delete();
        r104 = 0;
        c104 = 0;
        Rst  = 1'b1;

        for (int i = 0; i < 2 * BIG * BIG; i++) px104(rnd(), 0);
        repeat (3) step();
        chk("fresh frames count", n_out, 3 * FOUT);
        chk("fresh frames pending", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
